// File: rtl/tt_um_kavya_fifo_if.sv
// FIFO request/data bundle shared by producer, consumer and observers.
// Latency: none (wires only).
// Backpressure: full/empty flags; requests against them are dropped by the FIFO.
interface tt_um_kavya_fifo_if #(
    parameter int WIDTH = 4
);
    logic             wr_rq;
    logic             rd_rq;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] rdata;
    logic             full;
    logic             empty;
    logic             w_clk;
    logic             r_clk;

    // Producer/consumer side: drives requests, observes flags and clocks
    modport master (
        output wr_rq, rd_rq, wdata,
        input  rdata, full, empty, w_clk, r_clk
    );

    // FIFO side
    modport slave (
        input  wr_rq, rd_rq, wdata,
        output rdata, full, empty, w_clk, r_clk
    );
endinterface

// File: rtl/tt_um_kavya_fifo.sv
// Single-clock circular FIFO with internal write (clk/2) and read (clk/4) tick divider.
// Latency: write stored at its tick edge; rdata registered at the read-tick edge.
// Backpressure: write while full and read while empty are silently dropped.
module tt_um_kavya_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8
) (
    input  logic                 clk_in,
    input  logic                 reset,
    tt_um_kavya_fifo_if.slave    bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [1:0]       cnt_q, cnt_d;
    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    logic w_tick;
    logic r_tick;
    logic full;
    logic empty;
    logic do_wr;
    logic do_rd;

    // Ticks and flags all derive from pre-edge registered state, so a write and a
    // read landing on the same edge would each see the same full/empty view.
    always_comb begin
        w_tick = ~cnt_q[0];
        r_tick = (cnt_q == 2'b01);
        empty  = (wptr_q == rptr_q);
        full   = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
        do_wr  = w_tick && bus.wr_rq && !full;
        do_rd  = r_tick && bus.rd_rq && !empty;
    end

    // Next-state: divider, pointers, storage and read register
    always_comb begin
        cnt_d   = cnt_q + 2'd1;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        rdata_d = rdata_q;
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (do_wr) begin
            mem_d[wptr_q[AW-1:0]] = bus.wdata;
            wptr_d                = wptr_q + PTR_ONE;
        end
        if (do_rd) begin
            rdata_d = mem_q[rptr_q[AW-1:0]];
            rptr_d  = rptr_q + PTR_ONE;
        end
    end

    // State registers; synchronous reset wipes storage and overrides any tick
    always_ff @(posedge clk_in) begin
        if (reset) begin
            cnt_q   <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            rdata_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            cnt_q   <= cnt_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            rdata_q <= rdata_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign bus.rdata = rdata_q;
    assign bus.full  = full;
    assign bus.empty = empty;
    assign bus.w_clk = cnt_q[0];
    assign bus.r_clk = cnt_q[1];
endmodule

// File: tb/tb_tt_um_kavya_fifo.sv
// Directed bench for tt_um_kavya_fifo: reset, divider, fill/overflow, drain, wrap,
// concurrent traffic and mid-operation reset, with hand-computed expectations.
// Edges are counted from the first edge after reset release (edge 1).
module tb_tt_um_kavya_fifo;
    logic clk_in = 1'b0;
    logic reset  = 1'b1;
    int   n_chk  = 0;
    int   n_err  = 0;
    int   ecount = 0;

    tt_um_kavya_fifo_if #(.WIDTH(4)) bus ();

    tt_um_kavya_fifo #(.WIDTH(4), .DEPTH(8)) dut (
        .clk_in (clk_in),
        .reset  (reset),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clk_in edge; outputs sampled 1 time unit later
    task automatic step();
        @(posedge clk_in);
        #1;
        ecount++;
    endtask

    // Advance to and through the next write-tick edge (odd edge numbers)
    task automatic step_to_wr();
        do step(); while (ecount % 2 == 0);
    endtask

    // Advance to and through the next read-tick edge (edges 2,6,10,...)
    task automatic step_to_rd();
        do step(); while (ecount % 4 != 2);
    endtask

    task automatic do_reset(input int edges);
        reset = 1'b1;
        for (int i = 0; i < edges; i++) step();
        reset  = 1'b0;
        ecount = 0;
    endtask

    logic [3:0] wrap_dat [8];

    initial begin
        bus.wr_rq = 1'b0;
        bus.rd_rq = 1'b0;
        bus.wdata = '0;
        wrap_dat = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF, 4'h3, 4'h5};

        // Reset state
        do_reset(3);
        chk("rst_empty", bus.empty, 1);
        chk("rst_full",  bus.full,  0);
        chk("rst_rdata", bus.rdata, 0);
        chk("rst_wclk",  bus.w_clk, 0);
        chk("rst_rclk",  bus.r_clk, 0);

        // Divider waveforms over edges 1..4: w_clk 1,0,1,0 ; r_clk 0,1,1,0
        step(); chk("e1_wclk", bus.w_clk, 1); chk("e1_rclk", bus.r_clk, 0);
        step(); chk("e2_wclk", bus.w_clk, 0); chk("e2_rclk", bus.r_clk, 1);
        step(); chk("e3_wclk", bus.w_clk, 1); chk("e3_rclk", bus.r_clk, 1);
        step(); chk("e4_wclk", bus.w_clk, 0); chk("e4_rclk", bus.r_clk, 0);
        chk("idle_empty", bus.empty, 1);

        // Fill 1..8 on edges 1,3,...,15
        do_reset(3);
        bus.wr_rq = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            bus.wdata = 4'(i);
            step_to_wr();
            chk("fill_empty", bus.empty, 0);
            if (i == 7) begin
                step();  // edge 14: request outside a write tick is ignored
                chk("fill_e14_full", bus.full, 0);
            end
        end
        chk("fill_edge", ecount, 15);
        chk("fill_full", bus.full, 1);

        // Overflow: 9th write at edge 17 dropped
        bus.wdata = 4'd9;
        step_to_wr();
        chk("ovf_edge", ecount, 17);
        chk("ovf_full", bus.full, 1);

        // Drain 1..8 on edges 18,22,...,46
        bus.wr_rq = 1'b0;
        bus.rd_rq = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            step_to_rd();
            chk("drain_rdata", bus.rdata, 32'(i));
            chk("drain_full", bus.full, 0);
        end
        chk("drain_edge", ecount, 46);
        chk("drain_empty", bus.empty, 1);
        step_to_rd();
        chk("under_rdata", bus.rdata, 8);
        chk("under_empty", bus.empty, 1);

        // Wrap: write 5, read 5, then fill with 8 new words across the pointer wrap
        bus.rd_rq = 1'b0;
        bus.wr_rq = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            bus.wdata = 4'(i);
            step_to_wr();
        end
        bus.wr_rq = 1'b0;
        bus.rd_rq = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            step_to_rd();
            chk("wrap5_rdata", bus.rdata, 32'(i));
        end
        chk("wrap5_empty", bus.empty, 1);
        bus.rd_rq = 1'b0;
        bus.wr_rq = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.wdata = wrap_dat[i];
            step_to_wr();
            if (i == 6) chk("wrap_7_full", bus.full, 0);
        end
        chk("wrap_full", bus.full, 1);
        bus.wr_rq = 1'b0;
        bus.rd_rq = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step_to_rd();
            chk("wrap_rdata", bus.rdata, 32'(wrap_dat[i]));
        end
        chk("wrap_empty", bus.empty, 1);
        chk("wrap_nfull", bus.full, 0);

        // Concurrent: writes on odd edges (1..15 in order), reads on 2,6,...,30
        bus.rd_rq = 1'b0;
        do_reset(3);
        bus.wr_rq = 1'b1;
        bus.rd_rq = 1'b1;
        bus.wdata = 4'd1;
        for (int e = 1; e <= 30; e++) begin
            step();
            if (e % 2 == 1) bus.wdata = bus.wdata + 4'd1;
            if (e == 1) chk("cc_e1_empty", bus.empty, 0);
            if (e == 2) chk("cc_e2_empty", bus.empty, 1);
            if (e % 4 == 2) chk("cc_rdata", bus.rdata, 32'((e - 2) / 4 + 1));
            if (e == 28) chk("cc_e28_full", bus.full, 0);
            if (e == 29) chk("cc_e29_full", bus.full, 1);
        end
        chk("cc_e30_full", bus.full, 0);

        // Mid-operation reset with 3 entries stored
        bus.rd_rq = 1'b0;
        do_reset(3);
        bus.wr_rq = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            bus.wdata = 4'(i + 4);
            step_to_wr();
        end
        chk("mid_pre_empty", bus.empty, 0);
        bus.wr_rq = 1'b0;
        do_reset(1);
        chk("mid_empty", bus.empty, 1);
        chk("mid_rdata", bus.rdata, 0);
        chk("mid_full",  bus.full,  0);
        bus.wdata = 4'd7;
        bus.wr_rq = 1'b1;
        step_to_wr();
        bus.wr_rq = 1'b0;
        bus.rd_rq = 1'b1;
        step_to_rd();
        chk("mid_new_rdata", bus.rdata, 7);
        chk("mid_new_empty", bus.empty, 1);
        step_to_rd();
        chk("mid_stale_rdata", bus.rdata, 7);
        bus.rd_rq = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
